// File: rtl/ttt_game_engine.sv
// NxN, K-in-a-row two-player game engine: debounced commit buttons, turn control,
// illegal-move rejection, board storage, win/draw detection and new-game restart.
module ttt_game_engine #(
   parameter int N          = 3,
   parameter int K          = 3,
   parameter int DEB_CYCLES = 16,
   parameter int PW         = $clog2(N*N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              playin1,
   input  logic              playin2,
   input  logic              new_game,
   input  logic [PW-1:0]     position,
   output logic [2*N*N-1:0]  board,
   output logic [1:0]        win,
   output logic              turn,
   output logic              illegal,
   output logic              busy
);

   localparam int CELLS = N*N;
   localparam int CW    = $clog2(CELLS+1);
   localparam int DW    = $clog2(DEB_CYCLES);

   typedef enum logic [1:0] {S_WAIT, S_CHECK, S_OVER} state_t;

   state_t             r_state, w_stateNext;
   logic [2*CELLS-1:0] r_board, w_boardNext;
   logic [1:0]         r_win, w_winNext;
   logic               r_turn, w_turnNext;
   logic               r_illegal, w_illegalNext;
   logic [CW-1:0]      r_cnt, w_cntNext;

   logic [1:0]         r_sync1, r_sync2, r_deb, r_pulse;
   logic [DW-1:0]      r_debCnt [2];
   logic [1:0]         w_raw;

   logic [1:0]         w_cell;
   logic               w_inRange;
   logic               w_found;
   logic [1:0]         w_mover;
   logic               w_rightPlayer;

   assign w_raw = {playin2, playin1};

   // Debounced level flips only after DEB_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_pulse <= '0;
         for (int i = 0; i < 2; i++) r_debCnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            r_pulse[i] <= 1'b0;
            if (r_sync2[i] != r_deb[i]) begin
               if (r_debCnt[i] == DW'(DEB_CYCLES-1)) begin
                  r_deb[i]    <= r_sync2[i];
                  r_debCnt[i] <= '0;
                  r_pulse[i]  <= r_sync2[i];
               end else begin
                  r_debCnt[i] <= r_debCnt[i] + DW'(1);
               end
            end else begin
               r_debCnt[i] <= '0;
            end
         end
      end
   end

   function automatic logic runAt(input logic [2*CELLS-1:0] b, input logic [1:0] code,
                                  input int r, input int c, input int dr, input int dc);
      logic ok;
      int   rEnd, cEnd;
      ok   = 1'b1;
      rEnd = r + (K-1)*dr;
      cEnd = c + (K-1)*dc;
      if (rEnd < 0 || rEnd >= N || cEnd < 0 || cEnd >= N) begin
         ok = 1'b0;
      end else begin
         for (int k = 0; k < K; k++)
            if (b[2*((r+k*dr)*N + (c+k*dc)) +: 2] != code) ok = 1'b0;
      end
      return ok;
   endfunction

   // The player who just moved is the opposite of the (already toggled) turn
   assign w_mover = r_turn ? 2'b01 : 2'b10;

   always_comb begin
      w_found = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (runAt(r_board, w_mover, r, c, 0, 1) || runAt(r_board, w_mover, r, c, 1, 0) ||
                runAt(r_board, w_mover, r, c, 1, 1) || runAt(r_board, w_mover, r, c, 1, -1))
               w_found = 1'b1;
   end

   always_comb begin
      w_cell = 2'b00;
      for (int i = 0; i < CELLS; i++)
         if (position == PW'(i)) w_cell = r_board[2*i +: 2];
   end

   assign w_inRange     = int'(position) < CELLS;
   assign w_rightPlayer = r_pulse[0] ? ~r_turn : r_turn;

   always_comb begin
      w_stateNext   = r_state;
      w_boardNext   = r_board;
      w_winNext     = r_win;
      w_turnNext    = r_turn;
      w_cntNext     = r_cnt;
      w_illegalNext = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (r_pulse[0] || r_pulse[1]) begin
               if ((r_pulse[0] ^ r_pulse[1]) && w_rightPlayer && w_inRange && w_cell == 2'b00) begin
                  for (int i = 0; i < CELLS; i++)
                     if (position == PW'(i)) w_boardNext[2*i +: 2] = r_turn ? 2'b10 : 2'b01;
                  w_turnNext  = ~r_turn;
                  w_cntNext   = r_cnt + CW'(1);
                  w_stateNext = S_CHECK;
               end else begin
                  w_illegalNext = 1'b1;
               end
            end
         end
         S_CHECK: begin
            if (w_found) begin
               w_winNext   = w_mover;
               w_stateNext = S_OVER;
            end else if (r_cnt == CW'(CELLS)) begin
               w_winNext   = 2'b11;
               w_stateNext = S_OVER;
            end else begin
               w_stateNext = S_WAIT;
            end
         end
         S_OVER:  w_stateNext = S_OVER;
         default: w_stateNext = S_WAIT;
      endcase
      // Restart overrides any move decided in the same cycle
      if (new_game) begin
         w_boardNext   = '0;
         w_winNext     = 2'b00;
         w_turnNext    = 1'b0;
         w_cntNext     = '0;
         w_illegalNext = 1'b0;
         w_stateNext   = S_WAIT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_WAIT;
         r_board   <= '0;
         r_win     <= 2'b00;
         r_turn    <= 1'b0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_board   <= w_boardNext;
         r_win     <= w_winNext;
         r_turn    <= w_turnNext;
         r_illegal <= w_illegalNext;
         r_cnt     <= w_cntNext;
      end
   end

   assign board   = r_board;
   assign win     = r_win;
   assign turn    = r_turn;
   assign illegal = r_illegal;
   assign busy    = (r_state == S_CHECK);

endmodule

// File: tb/tb_ttt_game_engine.sv
// Directed self-checking bench: a 3x3/K=3 instance (A) and a 5x5/K=4 instance (B)
// share the buttons and new_game; each has its own reset and position.
module tb_ttt_game_engine;

   logic        clk = 1'b0;
   logic        resetA, resetB;
   logic        playin1, playin2, newGame;
   logic [3:0]  posA;
   logic [4:0]  posB;
   logic [17:0] boardA;
   logic [49:0] boardB;
   logic [1:0]  winA, winB;
   logic        turnA, turnB, illA, illB, busyA, busyB;

   int testsRun = 0;
   int testsFailed = 0;
   int illCntA, busyCntA, bChgA, wChgA;
   int illCntB, busyCntB, bChgB, wChgB;

   ttt_game_engine #(.N(3), .K(3), .DEB_CYCLES(4)) dutA (
      .clk(clk), .reset(resetA), .playin1(playin1), .playin2(playin2), .new_game(newGame),
      .position(posA), .board(boardA), .win(winA), .turn(turnA), .illegal(illA), .busy(busyA));

   ttt_game_engine #(.N(5), .K(4), .DEB_CYCLES(4)) dutB (
      .clk(clk), .reset(resetB), .playin1(playin1), .playin2(playin2), .new_game(newGame),
      .position(posB), .board(boardB), .win(winB), .turn(turnB), .illegal(illB), .busy(busyB));

   always #5 clk = ~clk;

   // player 1 or 2 presses one button, 3 presses both together
   task automatic press(input int player, input int pos);
      logic [17:0] prevBoardA;
      logic [49:0] prevBoardB;
      logic [1:0]  prevWinA, prevWinB;
      posA = pos[3:0];
      posB = pos[4:0];
      illCntA = 0; busyCntA = 0; bChgA = -1; wChgA = -1;
      illCntB = 0; busyCntB = 0; bChgB = -1; wChgB = -1;
      prevBoardA = boardA; prevWinA = winA;
      prevBoardB = boardB; prevWinB = winB;
      @(negedge clk);
      if (player == 1 || player == 3) playin1 = 1'b1;
      if (player == 2 || player == 3) playin2 = 1'b1;
      for (int cyc = 0; cyc < 28; cyc++) begin
         @(negedge clk);
         if (illA) illCntA++;
         if (busyA) busyCntA++;
         if (boardA != prevBoardA && bChgA < 0) bChgA = cyc;
         if (winA != prevWinA && wChgA < 0) wChgA = cyc;
         if (illB) illCntB++;
         if (busyB) busyCntB++;
         if (boardB != prevBoardB && bChgB < 0) bChgB = cyc;
         if (winB != prevWinB && wChgB < 0) wChgB = cyc;
         if (cyc == 12) begin
            playin1 = 1'b0;
            playin2 = 1'b0;
         end
      end
   endtask

   task automatic applyNewGame();
      @(negedge clk) newGame = 1'b1;
      @(negedge clk) newGame = 1'b0;
   endtask

   task automatic test_reset();
      resetA = 1'b0; resetB = 1'b0;
      #1;
      testsRun++;
      if (boardA !== 18'h0 || winA !== 2'b00 || turnA !== 1'b0 || illA !== 1'b0 || busyA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_A: got board=%h win=%b turn=%b ill=%b busy=%b expected all zero", boardA, winA, turnA, illA, busyA);
      end
      testsRun++;
      if (boardB !== 50'h0 || winB !== 2'b00 || turnB !== 1'b0 || illB !== 1'b0 || busyB !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_B: got board=%h win=%b turn=%b ill=%b busy=%b expected all zero", boardB, winB, turnB, illB, busyB);
      end
      repeat (3) @(negedge clk);
      resetA = 1'b1; resetB = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_row_win();
      applyNewGame();
      press(1, 0); press(2, 3); press(1, 1); press(2, 4); press(1, 2);
      testsRun++;
      if (boardA !== 18'h295) begin
         testsFailed++;
         $display("[TB] FAIL row_board: got %h expected %h", boardA, 18'h295);
      end
      testsRun++;
      if (winA !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL row_win: got %b expected 01", winA);
      end
      testsRun++;
      if (wChgA - bChgA !== 1 || busyCntA !== 1) begin
         testsFailed++;
         $display("[TB] FAIL row_win_latency: got win-board gap %0d busy %0d expected 1 and 1", wChgA - bChgA, busyCntA);
      end
      press(2, 5);
      testsRun++;
      if (boardA !== 18'h295 || winA !== 2'b01 || illCntA !== 0) begin
         testsFailed++;
         $display("[TB] FAIL gameover_ignore: got board=%h win=%b ill=%0d expected 295 01 0", boardA, winA, illCntA);
      end
      applyNewGame();
      testsRun++;
      if (boardA !== 18'h0 || winA !== 2'b00 || turnA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL new_game_clear: got board=%h win=%b turn=%b expected 0 00 0", boardA, winA, turnA);
      end
   endtask

   task automatic test_occupied();
      applyNewGame();
      press(1, 4);
      press(2, 4);
      testsRun++;
      if (illCntA !== 1) begin
         testsFailed++;
         $display("[TB] FAIL occupied_illegal: got %0d illegal cycles expected 1", illCntA);
      end
      testsRun++;
      if (boardA !== 18'h100 || turnA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL occupied_hold: got board=%h turn=%b expected 100 1", boardA, turnA);
      end
      press(2, 0);
      testsRun++;
      if (boardA !== 18'h102 || turnA !== 1'b0 || illCntA !== 0) begin
         testsFailed++;
         $display("[TB] FAIL occupied_retry: got board=%h turn=%b ill=%0d expected 102 0 0", boardA, turnA, illCntA);
      end
   endtask

   task automatic test_illegal_start();
      int pl [3] = '{2, 1, 3};
      int ps [3] = '{0, 9, 0};
      applyNewGame();
      for (int i = 0; i < 3; i++) begin
         press(pl[i], ps[i]);
         testsRun++;
         if (illCntA !== 1 || boardA !== 18'h0 || turnA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL illegal_case%0d: got ill=%0d board=%h turn=%b expected 1 0 0", i, illCntA, boardA, turnA);
         end
      end
   endtask

   task automatic test_draw();
      int          moves [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      logic [17:0] expBoard;
      int          busyTotal;
      expBoard  = '0;
      busyTotal = 0;
      applyNewGame();
      for (int i = 0; i < 9; i++) begin
         press((i % 2) + 1, moves[i]);
         expBoard[2*moves[i] +: 2] = (i % 2 == 0) ? 2'b01 : 2'b10;
         busyTotal += busyCntA;
         if (i == 7) begin
            testsRun++;
            if (winA !== 2'b00) begin
               testsFailed++;
               $display("[TB] FAIL draw_early: got win=%b expected 00", winA);
            end
         end
      end
      testsRun++;
      if (boardA !== expBoard || winA !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL draw_result: got board=%h win=%b expected %h 11", boardA, winA, expBoard);
      end
      testsRun++;
      if (busyTotal !== 9 || wChgA - bChgA !== 1) begin
         testsFailed++;
         $display("[TB] FAIL draw_busy: got busy=%0d gap=%0d expected 9 1", busyTotal, wChgA - bChgA);
      end
   endtask

   task automatic test_bounce();
      int ill = 0;
      applyNewGame();
      posA = 4'd0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (cyc % 2 == 0) playin1 = ~playin1;
         if (illA) ill++;
      end
      playin1 = 1'b0;
      repeat (12) @(negedge clk);
      testsRun++;
      if (boardA !== 18'h0 || turnA !== 1'b0 || ill !== 0) begin
         testsFailed++;
         $display("[TB] FAIL bounce_reject: got board=%h turn=%b ill=%0d expected 0 0 0", boardA, turnA, ill);
      end
   endtask

   task automatic test_reset_in_check();
      logic seen = 1'b0;
      applyNewGame();
      posA = 4'd4;
      playin1 = 1'b1;
      for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
         @(negedge clk);
         if (busyA) seen = 1'b1;
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL check_timeout: got busy=0 expected busy within 30 cycles");
      end
      resetA = 1'b0;
      #1;
      testsRun++;
      if (boardA !== 18'h0 || winA !== 2'b00 || turnA !== 1'b0 || busyA !== 1'b0 || illA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_in_check: got board=%h win=%b turn=%b busy=%b ill=%b expected all zero", boardA, winA, turnA, busyA, illA);
      end
      playin1 = 1'b0;
      repeat (3) @(negedge clk);
      resetA = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_k4_diagonal();
      int p1Moves [4] = '{0, 10, 24, 3};
      int p2Moves [4] = '{1, 7, 13, 19};
      applyNewGame();
      for (int i = 0; i < 4; i++) begin
         press(1, p1Moves[i]);
         press(2, p2Moves[i]);
         if (i == 2) begin
            testsRun++;
            if (winB !== 2'b00 || boardB[27:26] !== 2'b10) begin
               testsFailed++;
               $display("[TB] FAIL k4_three_run: got win=%b cell13=%b expected 00 10", winB, boardB[27:26]);
            end
         end
      end
      testsRun++;
      if (winB !== 2'b10 || boardB[39:38] !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL k4_win: got win=%b cell19=%b expected 10 10", winB, boardB[39:38]);
      end
      testsRun++;
      if (wChgB - bChgB !== 1) begin
         testsFailed++;
         $display("[TB] FAIL k4_latency: got gap=%0d expected 1", wChgB - bChgB);
      end
   endtask

   initial begin
      playin1 = 1'b0; playin2 = 1'b0; newGame = 1'b0;
      posA = '0; posB = '0;
      resetA = 1'b1; resetB = 1'b1;
      test_reset();
      test_row_win();
      test_occupied();
      test_illegal_start();
      test_draw();
      test_bounce();
      test_reset_in_check();
      test_k4_diagonal();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
